// File: rtl/fx_add_arbiter_if.sv
// Request/response bundle between the per-channel engines and the shared
// fixed-point adder arbiter.
interface fx_add_arbiter_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IW   = 2,
    parameter int unsigned FW   = 14
);
    localparam int unsigned W   = IW + FW;
    localparam int unsigned IDW = $clog2(NREQ);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_sum;
    logic              rsp_ovf;
    logic              rsp_unf;

    // Requesters plus result consumer
    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_ovf, rsp_unf
    );

    // Arbiter / adder
    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_ovf, rsp_unf
    );
endinterface

// File: rtl/fx_add_arbiter.sv
// Round-robin arbiter sharing one saturating signed Qi.f adder among NREQ
// requesters; single-entry registered result with valid/ready and a sat counter.
module fx_add_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IW   = 2,
    parameter int unsigned FW   = 14,
    parameter int unsigned CNTW = 16
) (
    input  logic                clk,
    input  logic                rst,
    fx_add_arbiter_if.slave     bus,
    input  logic                sat_clr,
    output logic [CNTW-1:0]     sat_cnt
);
    localparam int unsigned W   = IW + FW;
    localparam int unsigned IDW = $clog2(NREQ);
    localparam int unsigned PW  = IDW + 1;

    typedef enum logic {
        IDLE = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] rr_nxt;
    logic [IDW-1:0] grant_idx;
    logic           grant_found;
    logic [PW-1:0]  scan_idx;
    logic           can_accept_c;
    logic           accept_c;
    logic [W-1:0]   a_sel;
    logic [W-1:0]   b_sel;
    logic [W:0]     sum_raw;
    logic [W-1:0]   sum_sat;
    logic           ovf_c;
    logic           unf_c;

    // Round-robin search from rr_ptr upward, wrapping at NREQ
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            scan_idx = PW'(rr_ptr) + PW'(i);
            if (scan_idx >= PW'(NREQ)) begin
                scan_idx = scan_idx - PW'(NREQ);
            end
            if (!grant_found && bus.req_valid[scan_idx[IDW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx[IDW-1:0];
            end
        end
    end

    // The slot frees up this cycle if empty or being drained downstream
    always_comb begin
        can_accept_c = !rst && ((state == IDLE) || bus.rsp_ready);
        accept_c     = can_accept_c && grant_found;
    end

    always_comb begin
        bus.req_ready = '0;
        if (accept_c) begin
            bus.req_ready[grant_idx] = 1'b1;
        end
    end

    // Operand mux for the granted requester
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (grant_idx == IDW'(k)) begin
                a_sel = bus.req_a[k*W +: W];
                b_sel = bus.req_b[k*W +: W];
            end
        end
    end

    // W+1-bit sum; the top two bits disagree exactly when the result is out of range
    always_comb begin
        sum_raw = {a_sel[W-1], a_sel} + {b_sel[W-1], b_sel};
        ovf_c   = !sum_raw[W] &&  sum_raw[W-1];
        unf_c   =  sum_raw[W] && !sum_raw[W-1];
        if (ovf_c) begin
            sum_sat = {1'b0, {(W-1){1'b1}}};
        end else if (unf_c) begin
            sum_sat = {1'b1, {(W-1){1'b0}}};
        end else begin
            sum_sat = sum_raw[W-1:0];
        end
    end

    // Next-state logic for the single-entry result slot
    always_comb begin
        state_nxt = state;
        rr_nxt    = rr_ptr;
        case (state)
            IDLE: begin
                if (accept_c) begin
                    state_nxt = FULL;
                end
            end
            FULL: begin
                if (bus.rsp_ready && !accept_c) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (accept_c) begin
            rr_nxt = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            rr_ptr <= '0;
        end else begin
            state  <= state_nxt;
            rr_ptr <= rr_nxt;
        end
    end

    // Result register; only loads on accept so a stalled result stays put
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= '0;
            bus.rsp_sum   <= '0;
            bus.rsp_ovf   <= 1'b0;
            bus.rsp_unf   <= 1'b0;
        end else begin
            bus.rsp_valid <= (state_nxt == FULL);
            if (accept_c) begin
                bus.rsp_id  <= grant_idx;
                bus.rsp_sum <= sum_sat;
                bus.rsp_ovf <= ovf_c;
                bus.rsp_unf <= unf_c;
            end
        end
    end

    // Saturation-event counter; clear wins over a same-cycle event
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_cnt <= '0;
        end else if (sat_clr) begin
            sat_cnt <= '0;
        end else if (accept_c && (ovf_c || unf_c) && (sat_cnt != {CNTW{1'b1}})) begin
            sat_cnt <= sat_cnt + CNTW'(1);
        end
    end

endmodule

// File: tb/tb_fx_add_arbiter.sv
// Directed bench for fx_add_arbiter: grant order, saturation, stall, wrap,
// counter saturation/clear and asynchronous reset.
module tb_fx_add_arbiter;
    localparam int unsigned NREQ = 4;
    localparam int unsigned IW   = 2;
    localparam int unsigned FW   = 14;
    localparam int unsigned CNTW = 4;   // narrow counter so it reaches all-ones quickly
    localparam int unsigned W    = IW + FW;

    logic            clk = 1'b0;
    logic            rst;
    logic            sat_clr;
    logic [CNTW-1:0] sat_cnt;
    int              n_cmp = 0;
    int              n_err = 0;

    fx_add_arbiter_if #(.NREQ(NREQ), .IW(IW), .FW(FW)) bus ();

    fx_add_arbiter #(.NREQ(NREQ), .IW(IW), .FW(FW), .CNTW(CNTW)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .sat_clr (sat_clr),
        .sat_cnt (sat_cnt)
    );

    always #5 clk = ~clk;

    // {valid, id, sum, ovf, unf}
    logic [20:0] rsp_obs;
    assign rsp_obs = {bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.rsp_ovf, bus.rsp_unf};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int k, input logic [15:0] a, input logic [15:0] b);
        bus.req_a[k*16 +: 16] = a;
        bus.req_b[k*16 +: 16] = b;
    endtask

    task automatic test_reset();
        #3;
        bus.req_valid = 4'hF;
        bus.rsp_ready = 1'b1;
        #1;
        if (bus.req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready: got %b want 0000", bus.req_ready); end
        n_cmp++;
        if (rsp_obs !== 21'h0) begin n_err++; $display("FAIL reset_rsp: got %h want 000000", rsp_obs); end
        n_cmp++;
        if (sat_cnt !== 4'h0) begin n_err++; $display("FAIL reset_cnt: got %h want 0", sat_cnt); end
        n_cmp++;
        tick();
        if (rsp_obs !== 21'h0) begin n_err++; $display("FAIL reset_rsp_clk: got %h want 000000", rsp_obs); end
        n_cmp++;
        rst = 1'b0;
        bus.req_valid = 4'h0;
        tick();
        if (rsp_obs !== 21'h0) begin n_err++; $display("FAIL reset_idle: got %h want 000000", rsp_obs); end
        n_cmp++;
    endtask

    task automatic test_round_robin();
        logic [1:0]  exp_id;
        logic [15:0] exp_sum;
        logic [3:0]  exp_rdy;
        for (int k = 0; k < 4; k++) set_op(k, 16'(k * 16'h0100), 16'h0010);
        bus.req_valid = 4'hF;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_id  = 2'(i % 4);
            exp_sum = 16'h0100 * 16'(exp_id) + 16'h0010;
            exp_rdy = 4'b0001 << exp_id;
            #1;
            if (bus.req_ready !== exp_rdy) begin n_err++; $display("FAIL rr_ready[%0d]: got %b want %b", i, bus.req_ready, exp_rdy); end
            n_cmp++;
            tick();
            if (rsp_obs !== {1'b1, exp_id, exp_sum, 2'b00}) begin
                n_err++; $display("FAIL rr_rsp[%0d]: got %h want %h", i, rsp_obs, {1'b1, exp_id, exp_sum, 2'b00});
            end
            n_cmp++;
        end
        bus.req_valid = 4'h0;
        tick();
        if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL rr_drain: got %b want 0", bus.rsp_valid); end
        n_cmp++;
    endtask

    task automatic test_basic();
        set_op(0, 16'h2000, 16'h1000);
        bus.req_valid = 4'b0001;
        bus.rsp_ready = 1'b1;
        #1;
        if (bus.req_ready !== 4'b0001) begin n_err++; $display("FAIL basic_ready: got %b want 0001", bus.req_ready); end
        n_cmp++;
        tick();
        bus.req_valid = 4'b0000;
        if (rsp_obs !== {1'b1, 2'd0, 16'h3000, 2'b00}) begin
            n_err++; $display("FAIL basic_rsp: got %h want %h", rsp_obs, {1'b1, 2'd0, 16'h3000, 2'b00});
        end
        n_cmp++;
        tick();
        if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL basic_drain: got %b want 0", bus.rsp_valid); end
        n_cmp++;
    endtask

    task automatic test_saturate();
        logic [15:0] av [4];
        logic [15:0] bv [4];
        logic [15:0] sv [4];
        logic [1:0]  fl [4];
        logic [3:0]  cv [4];
        av = '{16'h6000, 16'h8000, 16'h4000, 16'hC000};
        bv = '{16'h4000, 16'hC000, 16'h3FFF, 16'hC000};
        sv = '{16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000};
        fl = '{2'b10, 2'b01, 2'b00, 2'b00};
        cv = '{4'd1, 4'd2, 4'd2, 4'd2};
        set_op(0, av[0], bv[0]);
        bus.req_valid = 4'b0001;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (rsp_obs !== {1'b1, 2'd0, sv[i], fl[i]}) begin
                n_err++; $display("FAIL sat_rsp[%0d]: got %h want %h", i, rsp_obs, {1'b1, 2'd0, sv[i], fl[i]});
            end
            n_cmp++;
            if (sat_cnt !== cv[i]) begin n_err++; $display("FAIL sat_cnt[%0d]: got %0d want %0d", i, sat_cnt, cv[i]); end
            n_cmp++;
            if (i < 3) set_op(0, av[i+1], bv[i+1]);
        end
        bus.req_valid = 4'b0000;
        tick();
        if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL sat_drain: got %b want 0", bus.rsp_valid); end
        n_cmp++;
    endtask

    task automatic test_hold();
        set_op(0, 16'h0100, 16'h0200);
        set_op(1, 16'h1111, 16'h2222);
        set_op(2, 16'h0001, 16'h0002);
        bus.req_valid = 4'b0001;
        bus.rsp_ready = 1'b0;
        tick();
        bus.req_valid = 4'b0110;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (bus.req_ready !== 4'b0000) begin n_err++; $display("FAIL hold_ready[%0d]: got %b want 0000", i, bus.req_ready); end
            n_cmp++;
            if (rsp_obs !== {1'b1, 2'd0, 16'h0300, 2'b00}) begin
                n_err++; $display("FAIL hold_rsp[%0d]: got %h want %h", i, rsp_obs, {1'b1, 2'd0, 16'h0300, 2'b00});
            end
            n_cmp++;
            tick();
        end
        bus.rsp_ready = 1'b1;
        #1;
        if (bus.req_ready !== 4'b0010) begin n_err++; $display("FAIL hold_next_ready: got %b want 0010", bus.req_ready); end
        n_cmp++;
        tick();
        if (rsp_obs !== {1'b1, 2'd1, 16'h3333, 2'b00}) begin
            n_err++; $display("FAIL hold_next_rsp: got %h want %h", rsp_obs, {1'b1, 2'd1, 16'h3333, 2'b00});
        end
        n_cmp++;
        #1;
        if (bus.req_ready !== 4'b0100) begin n_err++; $display("FAIL hold_then_ready: got %b want 0100", bus.req_ready); end
        n_cmp++;
        tick();
        bus.req_valid = 4'b0000;
        if (rsp_obs !== {1'b1, 2'd2, 16'h0003, 2'b00}) begin
            n_err++; $display("FAIL hold_then_rsp: got %h want %h", rsp_obs, {1'b1, 2'd2, 16'h0003, 2'b00});
        end
        n_cmp++;
        tick();
    endtask

    task automatic test_wrap();
        set_op(3, 16'h0100, 16'hFF00);
        set_op(0, 16'h0005, 16'h0007);
        bus.req_valid = 4'b1001;
        bus.rsp_ready = 1'b1;
        #1;
        if (bus.req_ready !== 4'b1000) begin n_err++; $display("FAIL wrap_ready3: got %b want 1000", bus.req_ready); end
        n_cmp++;
        tick();
        if (rsp_obs !== {1'b1, 2'd3, 16'h0000, 2'b00}) begin
            n_err++; $display("FAIL wrap_rsp3: got %h want %h", rsp_obs, {1'b1, 2'd3, 16'h0000, 2'b00});
        end
        n_cmp++;
        #1;
        if (bus.req_ready !== 4'b0001) begin n_err++; $display("FAIL wrap_ready0: got %b want 0001", bus.req_ready); end
        n_cmp++;
        tick();
        bus.req_valid = 4'b0000;
        if (rsp_obs !== {1'b1, 2'd0, 16'h000C, 2'b00}) begin
            n_err++; $display("FAIL wrap_rsp0: got %h want %h", rsp_obs, {1'b1, 2'd0, 16'h000C, 2'b00});
        end
        n_cmp++;
        tick();
    endtask

    task automatic test_sat_cnt();
        logic [3:0] exp_cnt;
        set_op(0, 16'h7FFF, 16'h0001);
        bus.req_valid = 4'b0001;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            tick();
            exp_cnt = (i + 3 > 15) ? 4'hF : 4'(i + 3);
            if (sat_cnt !== exp_cnt) begin n_err++; $display("FAIL cnt_step[%0d]: got %0d want %0d", i, sat_cnt, exp_cnt); end
            n_cmp++;
        end
        if (rsp_obs !== {1'b1, 2'd0, 16'h7FFF, 2'b10}) begin
            n_err++; $display("FAIL cnt_rsp: got %h want %h", rsp_obs, {1'b1, 2'd0, 16'h7FFF, 2'b10});
        end
        n_cmp++;
        sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
        if (sat_cnt !== 4'h0) begin n_err++; $display("FAIL cnt_clr: got %0d want 0", sat_cnt); end
        n_cmp++;
        tick();
        bus.req_valid = 4'b0000;
        if (sat_cnt !== 4'h1) begin n_err++; $display("FAIL cnt_after_clr: got %0d want 1", sat_cnt); end
        n_cmp++;
        tick();
    endtask

    task automatic test_async_reset();
        set_op(0, 16'h0100, 16'h0100);
        bus.req_valid = 4'b0001;
        bus.rsp_ready = 1'b0;
        tick();
        if (rsp_obs !== {1'b1, 2'd0, 16'h0200, 2'b00}) begin
            n_err++; $display("FAIL arst_pending: got %h want %h", rsp_obs, {1'b1, 2'd0, 16'h0200, 2'b00});
        end
        n_cmp++;
        bus.req_valid = 4'hF;
        #2;
        rst = 1'b1;
        #1;
        if (rsp_obs !== 21'h0) begin n_err++; $display("FAIL arst_rsp: got %h want 000000", rsp_obs); end
        n_cmp++;
        if (bus.req_ready !== 4'b0000) begin n_err++; $display("FAIL arst_ready: got %b want 0000", bus.req_ready); end
        n_cmp++;
        if (sat_cnt !== 4'h0) begin n_err++; $display("FAIL arst_cnt: got %0d want 0", sat_cnt); end
        n_cmp++;
        tick();
        rst = 1'b0;
        bus.req_valid = 4'h0;
        tick();
        if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL arst_no_rsp: got %b want 0", bus.rsp_valid); end
        n_cmp++;
        bus.req_valid = 4'hF;
        bus.rsp_ready = 1'b1;
        #1;
        if (bus.req_ready !== 4'b0001) begin n_err++; $display("FAIL arst_first_grant: got %b want 0001", bus.req_ready); end
        n_cmp++;
        tick();
        bus.req_valid = 4'h0;
        if (rsp_obs !== {1'b1, 2'd0, 16'h0200, 2'b00}) begin
            n_err++; $display("FAIL arst_first_rsp: got %h want %h", rsp_obs, {1'b1, 2'd0, 16'h0200, 2'b00});
        end
        n_cmp++;
        tick();
    endtask

    initial begin
        rst           = 1'b1;
        sat_clr       = 1'b0;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_round_robin();
        test_basic();
        test_saturate();
        test_hold();
        test_wrap();
        test_sat_cnt();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
